fork_detector_debounced: RTL and testbench
==========================================

// Module: fork_detector_debounced
// PURPOSE
//  Line-tracking fork detector for the car's sensor bar, generalised in sensor count and thresholds.
//  Flags a fork when at least ZERO_THRESH non-ignored sensors read 0 in one sample.
//  Provides a registered raw flag, a debounced level with one-cycle entry pulse, and post-release holdoff.
//  Also keeps a saturating fork counter. Sits between the sensor inputs and the steering/route FSM.
// PARAMETERS
//  N_SENS       4        number of detector bits
//  IGNORE_MASK  4'b0100  width N_SENS; 1 = bit excluded from the zero count
//  ZERO_THRESH  2        raw match when zero count of non-ignored bits >= this (1..N_SENS)
//  DEBOUNCE     4        consecutive matching samples needed to confirm (>=1)
//  HOLDOFF_CYC  16       cycles after release before re-arm (0 = none)
//  CNT_W        8        width of fork_count
// PORTS
//  clk              in   1       system clock, all logic on rising edge
//  rst_n            in   1       asynchronous reset, active low
//  en               in   1       detector enable; low = FSM forced to IDLE
//  clr_count        in   1       synchronous clear of fork_count
//  detector_signal  in   N_SENS  raw sensor bits, 0 = sensor off line
//  raw_fork         out  1       registered raw match, 1-cycle latency, no debounce
//  fork_level       out  1       high while state == ACTIVE
//  fork_pulse       out  1       one-cycle pulse on entry to ACTIVE
//  fork_count       out  CNT_W   number of confirmed forks, saturating
//  state_dbg        out  2       IDLE=0, CONFIRM=1, ACTIVE=2, HOLDOFF=3
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state IDLE, internal counters 0; effective immediately.
//  match (combinational):
//    popcount(~detector_signal & ~IGNORE_MASK) >= ZERO_THRESH.
//    With the defaults this equals the legacy set 0x01, 0x10, 1x00, 0x00.
//  raw_fork <= match every cycle, independent of en.
//  FSM, evaluated each edge when en=1:
//    IDLE: match -> CONFIRM with cnt=1. If DEBOUNCE==1, go straight to ACTIVE.
//    CONFIRM: !match -> IDLE.
//             match and cnt==DEBOUNCE-1 -> ACTIVE.
//             otherwise cnt++.
//    ACTIVE: stay while match. !match -> HOLDOFF with cnt=0, or IDLE if HOLDOFF_CYC==0.
//    HOLDOFF: ignores match. cnt++ each cycle; cnt==HOLDOFF_CYC-1 -> IDLE.
//  Latency: input matching from edge k reaches ACTIVE at edge k+DEBOUNCE-1.
//    fork_level is visible after that edge.
//  fork_pulse is registered: high exactly in the first cycle fork_level is high.
//    A new pulse only after passing back through IDLE.
//  fork_count increments on the same edge fork_pulse rises. Saturates at 2^CNT_W-1 (no wrap).
//  clr_count=1 sets fork_count to 0. Clear wins over a simultaneous increment.
//  en=0: next edge state=IDLE, cnt=0, fork_level=0, fork_pulse=0.
//    fork_count is held; raw_fork still updates.
//  Re-enable starts from IDLE. A glitch mid-CONFIRM restarts the debounce from 0.
//  cnt width is clog2(max(DEBOUNCE,HOLDOFF_CYC,2)). No arithmetic overflow is possible.
// TESTING
//  1 Reset: assert rst_n=0 mid-ACTIVE -> all outputs 0 without a clock edge; state_dbg=0.
//  2 Raw decode: sweep all 16 values of detector_signal with defaults.
//    -> raw_fork=1 one cycle later only for 0x01, 0x10, 1x00, 0x00 (8 codes).
//  3 Debounce: hold 4'b0000 for 4 cycles -> fork_pulse=1 for 1 cycle, fork_level=1, fork_count=1.
//    Hold for 3 cycles then 4'b1111 -> no pulse, state back to 0.
//  4 Holdoff: confirm a fork, release for 1 cycle, re-apply 4'b0000 at once.
//    -> no new pulse for 16 cycles; pulse at cycle 16+4 after release; fork_count=2.
//  5 Saturation/clear: CNT_W=2, confirm 5 forks -> fork_count stays at 3.
//    clr_count on an increment edge -> fork_count=0.
//  6 Enable: drop en in ACTIVE -> fork_level=0 next edge, fork_count held.
//    Raise en with input matching -> new pulse after 4 cycles.

Source files
------------

// File: rtl/fork_detector_debounced.sv
// fork_detector_debounced: sensor-bar fork detector with debounce, entry pulse, holdoff and saturating count
module fork_detector_debounced #(
  parameter int                N_SENS      = 4,
  parameter logic [N_SENS-1:0] IGNORE_MASK = 4'b0100,
  parameter int                ZERO_THRESH = 2,
  parameter int                DEBOUNCE    = 4,
  parameter int                HOLDOFF_CYC = 16,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr_count,
  input  logic [N_SENS-1:0] detector_signal,
  output logic              raw_fork,
  output logic              fork_level,
  output logic              fork_pulse,
  output logic [CNT_W-1:0]  fork_count,
  output logic [1:0]        state_dbg
);
  localparam int MAXC = (DEBOUNCE > HOLDOFF_CYC) ? DEBOUNCE : HOLDOFF_CYC;
  localparam int CW   = $clog2((MAXC > 2) ? MAXC : 2);
  localparam int PW   = $clog2(N_SENS + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, CONFIRM = 2'd1, ACTIVE = 2'd2, HOLDOFF = 2'd3} state_t;
  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [PW-1:0]       w_zeros;
  logic [N_SENS-1:0]   w_off;
  logic                w_match, w_enter;
  logic                r_raw, r_pulse;
  logic [CNT_W-1:0]    r_count;
  assign w_off = ~detector_signal & ~IGNORE_MASK;
  // count the non-ignored sensors that are off the line
  always_comb begin
    w_zeros = '0;
    for (int i = 0; i < N_SENS; i++) w_zeros = w_zeros + PW'(w_off[i]);
  end
  assign w_match = int'(w_zeros) >= ZERO_THRESH;
  // debounce / holdoff state machine; en low forces IDLE with a cleared counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: if (w_match) begin
          w_state_nxt = (DEBOUNCE == 1) ? ACTIVE : CONFIRM;
          w_cnt_nxt   = (DEBOUNCE == 1) ? '0 : CW'(1);
        end
        CONFIRM: begin
          w_state_nxt = !w_match ? IDLE : (r_cnt == CW'(DEBOUNCE - 1)) ? ACTIVE : CONFIRM;
          w_cnt_nxt   = (w_state_nxt == CONFIRM) ? r_cnt + CW'(1) : '0;
        end
        ACTIVE: if (!w_match) begin
          w_state_nxt = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
          w_cnt_nxt   = '0;
        end
        HOLDOFF: begin
          w_state_nxt = (r_cnt == CW'(HOLDOFF_CYC - 1)) ? IDLE : HOLDOFF;
          w_cnt_nxt   = (w_state_nxt == HOLDOFF) ? r_cnt + CW'(1) : '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end
  assign w_enter = (w_state_nxt == ACTIVE) && (r_state != ACTIVE);
  // state, raw flag, entry pulse and saturating fork counter (clear beats increment)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_raw   <= 1'b0;
      r_pulse <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_raw   <= w_match;
      r_pulse <= w_enter;
      r_count <= clr_count ? '0 : (w_enter && r_count != '1) ? r_count + CNT_W'(1) : r_count;
    end
  end
  assign raw_fork   = r_raw;
  assign fork_level = r_state == ACTIVE;
  assign fork_pulse = r_pulse;
  assign fork_count = r_count;
  assign state_dbg  = r_state;
endmodule

// File: tb/tb_fork_detector_debounced.sv
// tb_fork_detector_debounced: directed checks of decode, debounce, holdoff, saturation, enable and async reset
module tb_fork_detector_debounced;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] det = 4'hF;
  logic       raw, lvl, pls, s_raw, s_lvl, s_pls;
  logic [7:0] cnt;
  logic [1:0] s_cnt, st, s_st;
  int         n_cmp = 0;
  int         n_err = 0;

  fork_detector_debounced u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_count(clr), .detector_signal(det),
    .raw_fork(raw), .fork_level(lvl), .fork_pulse(pls), .fork_count(cnt), .state_dbg(st));

  fork_detector_debounced #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_count(clr), .detector_signal(det),
    .raw_fork(s_raw), .fork_level(s_lvl), .fork_pulse(s_pls), .fork_count(s_cnt), .state_dbg(s_st));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_idle();
    det = 4'hF;
    tick(17);
  endtask

  task automatic test_reset_init();
    #1;
    n_cmp++; if ({raw, lvl, pls, cnt, st} !== 13'd0) begin n_err++; $display("FAIL init_reset got=%0h exp=0", {raw, lvl, pls, cnt, st}); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if (st !== 2'd0) begin n_err++; $display("FAIL init_state got=%0d exp=0", st); end
  endtask

  task automatic test_raw_decode();
    logic [15:0] tbl;
    tbl = 16'h1177;
    for (int v = 0; v < 16; v++) begin
      det = 4'(v);
      tick(1);
      n_cmp++; if (raw !== tbl[v]) begin n_err++; $display("FAIL raw_decode[%0h] got=%0b exp=%0b", v, raw, tbl[v]); end
    end
    det = 4'hF;
    tick(1);
    n_cmp++; if (st !== 2'd0 || cnt !== 8'd0) begin n_err++; $display("FAIL raw_after state=%0d cnt=%0d exp 0/0", st, cnt); end
  endtask

  task automatic test_debounce();
    det = 4'h0;
    tick(3);
    n_cmp++; if (st !== 2'd1 || pls !== 1'b0) begin n_err++; $display("FAIL deb_confirm state=%0d pulse=%0b exp 1/0", st, pls); end
    tick(1);
    n_cmp++; if (st !== 2'd2 || lvl !== 1'b1 || pls !== 1'b1 || cnt !== 8'd1) begin n_err++; $display("FAIL deb_entry state=%0d lvl=%0b pulse=%0b cnt=%0d exp 2/1/1/1", st, lvl, pls, cnt); end
    tick(1);
    n_cmp++; if (lvl !== 1'b1 || pls !== 1'b0 || cnt !== 8'd1) begin n_err++; $display("FAIL deb_hold lvl=%0b pulse=%0b cnt=%0d exp 1/0/1", lvl, pls, cnt); end
    det = 4'hF;
    tick(1);
    n_cmp++; if (st !== 2'd3 || lvl !== 1'b0) begin n_err++; $display("FAIL deb_release state=%0d lvl=%0b exp 3/0", st, lvl); end
    tick(15);
    n_cmp++; if (st !== 2'd3) begin n_err++; $display("FAIL deb_holdoff15 state=%0d exp 3", st); end
    tick(1);
    n_cmp++; if (st !== 2'd0) begin n_err++; $display("FAIL deb_holdoff16 state=%0d exp 0", st); end
    det = 4'h0;
    tick(3);
    det = 4'hF;
    tick(1);
    n_cmp++; if (st !== 2'd0 || pls !== 1'b0 || cnt !== 8'd1) begin n_err++; $display("FAIL deb_short state=%0d pulse=%0b cnt=%0d exp 0/0/1", st, pls, cnt); end
    det = 4'h0;
    tick(2);
    det = 4'hF;
    tick(1);
    det = 4'h0;
    tick(3);
    n_cmp++; if (st !== 2'd1 || pls !== 1'b0) begin n_err++; $display("FAIL deb_glitch state=%0d pulse=%0b exp 1/0", st, pls); end
    det = 4'hF;
    tick(1);
  endtask

  task automatic test_holdoff();
    logic [1:0] exp_st;
    det = 4'h0;
    tick(4);
    n_cmp++; if (pls !== 1'b1 || cnt !== 8'd2) begin n_err++; $display("FAIL hold_first pulse=%0b cnt=%0d exp 1/2", pls, cnt); end
    det = 4'hF;
    tick(1);
    det = 4'h0;
    for (int j = 1; j <= 19; j++) begin
      tick(1);
      exp_st = (j < 16) ? 2'd3 : (j == 16) ? 2'd0 : 2'd1;
      n_cmp++; if (pls !== 1'b0 || st !== exp_st) begin n_err++; $display("FAIL hold_wait[%0d] pulse=%0b state=%0d exp 0/%0d", j, pls, st, exp_st); end
    end
    tick(1);
    n_cmp++; if (pls !== 1'b1 || lvl !== 1'b1 || cnt !== 8'd3) begin n_err++; $display("FAIL hold_repulse pulse=%0b lvl=%0b cnt=%0d exp 1/1/3", pls, lvl, cnt); end
    release_idle();
  endtask

  task automatic test_saturation();
    n_cmp++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL sat_pre cnt=%0d exp 3", s_cnt); end
    for (int k = 4; k <= 5; k++) begin
      det = 4'h0;
      tick(4);
      n_cmp++; if (s_pls !== 1'b1 || s_cnt !== 2'd3 || cnt !== 8'(k)) begin n_err++; $display("FAIL sat_fork%0d spulse=%0b scnt=%0d cnt=%0d exp 1/3/%0d", k, s_pls, s_cnt, cnt, k); end
      release_idle();
    end
    det = 4'h0;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_cmp++; if (pls !== 1'b1 || cnt !== 8'd0 || s_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clear pulse=%0b cnt=%0d scnt=%0d exp 1/0/0", pls, cnt, s_cnt); end
    release_idle();
  endtask

  task automatic test_enable();
    det = 4'h0;
    tick(4);
    n_cmp++; if (lvl !== 1'b1 || cnt !== 8'd1) begin n_err++; $display("FAIL en_active lvl=%0b cnt=%0d exp 1/1", lvl, cnt); end
    en = 1'b0;
    tick(1);
    n_cmp++; if (lvl !== 1'b0 || st !== 2'd0 || pls !== 1'b0 || cnt !== 8'd1) begin n_err++; $display("FAIL en_drop lvl=%0b state=%0d pulse=%0b cnt=%0d exp 0/0/0/1", lvl, st, pls, cnt); end
    tick(2);
    n_cmp++; if (st !== 2'd0 || raw !== 1'b1) begin n_err++; $display("FAIL en_off_match state=%0d raw=%0b exp 0/1", st, raw); end
    det = 4'hF;
    tick(1);
    n_cmp++; if (raw !== 1'b0) begin n_err++; $display("FAIL en_off_raw raw=%0b exp 0", raw); end
    det = 4'h0;
    en = 1'b1;
    tick(3);
    n_cmp++; if (st !== 2'd1 || pls !== 1'b0) begin n_err++; $display("FAIL en_reconfirm state=%0d pulse=%0b exp 1/0", st, pls); end
    tick(1);
    n_cmp++; if (pls !== 1'b1 || cnt !== 8'd2) begin n_err++; $display("FAIL en_repulse pulse=%0b cnt=%0d exp 1/2", pls, cnt); end
    release_idle();
  endtask

  task automatic test_reset_async();
    det = 4'h0;
    tick(4);
    n_cmp++; if (lvl !== 1'b1 || cnt !== 8'd3) begin n_err++; $display("FAIL rst_pre lvl=%0b cnt=%0d exp 1/3", lvl, cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({raw, lvl, pls, cnt, st} !== 13'd0) begin n_err++; $display("FAIL rst_async got=%0h exp=0", {raw, lvl, pls, cnt, st}); end
    n_cmp++; if ({s_raw, s_lvl, s_pls, s_cnt, s_st} !== 7'd0) begin n_err++; $display("FAIL rst_async_sat got=%0h exp=0", {s_raw, s_lvl, s_pls, s_cnt, s_st}); end
    det = 4'hF;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (st !== 2'd0 || cnt !== 8'd0) begin n_err++; $display("FAIL rst_after state=%0d cnt=%0d exp 0/0", st, cnt); end
  endtask

  initial begin
    test_reset_init();
    test_raw_decode();
    test_debounce();
    test_holdoff();
    test_saturation();
    test_enable();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
